// File: rtl/cache_pkg.sv
// Shared definitions for the instruction cache: miss FSM encoding
// and index-width helper.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_e;

    function automatic int index_w(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Flop-based tag/data/valid storage for the direct-mapped cache:
// async read, one write port, clear-all beats the write.
module inst_cache_array
    import cache_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [31:0]        rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [31:0]        wr_data_i,
    input  logic               wr_valid_i,
    input  logic               clr_i
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    // Payload needs no reset: it is only trusted behind valid_q.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache, one word per line, with a blocking
// miss sequence towards the memory bus.
module inst_cache_dm
    import cache_pkg::*;
#(
    parameter int          ENTRIES    = 16,
    parameter logic [31:0] CACHE_BASE = 32'h2000_0000,
    parameter logic [31:0] CACHE_SIZE = 32'h1000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    output logic        MEM_WAIT,
    input  logic        FLUSH,
    input  logic        INVALIDATE,
    output logic        BUS_RREQ,
    output logic [31:0] BUS_RADDR,
    input  logic        BUS_RACK,
    input  logic        BUS_RVALID,
    input  logic [31:0] BUS_RDATA
);

    localparam int INDEX_W = index_w(ENTRIES);
    localparam int TAG_W   = 30 - INDEX_W;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [29:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic        inv_q, inv_d;
    logic [31:0] fill_q, fill_d;
    logic [31:0] rdata_q, roaddr_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        word_addr;
    logic [31:0]        win_off;
    logic               cacheable;
    logic               arr_valid;
    logic [TAG_W-1:0]   arr_tag;
    logic [31:0]        arr_data;
    logic               lookup, hit, miss, deliver;
    logic               unused_lsb;

    assign unused_lsb = ^INST_RIADDR[1:0];

    assign idx       = addr_q[INDEX_W-1:0];
    assign tag       = addr_q[29:INDEX_W];
    assign word_addr = {addr_q, 2'b00};
    // Offset compare handles the window without overflow at its top.
    assign win_off   = word_addr - CACHE_BASE;
    assign cacheable = win_off < CACHE_SIZE;

    inst_cache_array #(
        .ENTRIES (ENTRIES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_idx_i   (idx),
        .rd_valid_o (arr_valid),
        .rd_tag_o   (arr_tag),
        .rd_data_o  (arr_data),
        .wr_en_i    (state_q == ST_DONE),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (fill_q),
        .wr_valid_i (cacheable && !inv_q),
        .clr_i      (INVALIDATE)
    );

    assign lookup  = (state_q == ST_IDLE) && pend_q;
    assign hit     = lookup && arr_valid && (arr_tag == tag) && cacheable;
    assign miss    = lookup && !hit;
    assign deliver = (hit && !FLUSH) || ((state_q == ST_DONE) && !drop_q);

    assign MEM_WAIT    = miss || (state_q == ST_REQ) || (state_q == ST_RESP);
    assign INST_RVALID = deliver;
    assign INST_RDATA  = !deliver ? rdata_q
                       : (state_q == ST_DONE) ? fill_q : arr_data;
    assign INST_ROADDR = deliver ? word_addr : roaddr_q;
    assign BUS_RREQ    = (state_q == ST_REQ);
    assign BUS_RADDR   = word_addr;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        inv_d   = inv_q;
        fill_d  = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    state_d = ST_REQ;
                    pend_d  = 1'b0;
                    drop_d  = FLUSH;
                    inv_d   = INVALIDATE;
                end else begin
                    pend_d = INST_RDEN;
                    if (INST_RDEN) begin
                        addr_d = INST_RIADDR[31:2];
                    end
                end
            end
            ST_REQ: begin
                drop_d = drop_q | FLUSH;
                inv_d  = inv_q | INVALIDATE;
                if (BUS_RACK) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                drop_d = drop_q | FLUSH;
                inv_d  = inv_q | INVALIDATE;
                if (BUS_RVALID) begin
                    fill_d  = BUS_RDATA;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            addr_q   <= '0;
            drop_q   <= 1'b0;
            inv_q    <= 1'b0;
            fill_q   <= '0;
            rdata_q  <= '0;
            roaddr_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            addr_q   <= addr_d;
            drop_q   <= drop_d;
            inv_q    <= inv_d;
            fill_q   <= fill_d;
            rdata_q  <= INST_RDATA;
            roaddr_q <= INST_ROADDR;
        end
    end

endmodule

// File: tb/tb_inst_cache_dm.sv
// Randomised bench for inst_cache_dm with an address-level cache model
// and a bus responder with variable latency.
module tb_inst_cache_dm;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] SIZE = 32'h1000_0000;
    localparam int          N    = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INST_RDEN, FLUSH, INVALIDATE, BUS_RACK, BUS_RVALID;
    logic [31:0] INST_RIADDR, BUS_RDATA;
    logic        INST_RVALID, MEM_WAIT, BUS_RREQ;
    logic [31:0] INST_ROADDR, INST_RDATA, BUS_RADDR;

    inst_cache_dm #(
        .ENTRIES    (N),
        .CACHE_BASE (BASE),
        .CACHE_SIZE (SIZE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .INST_RDEN   (INST_RDEN),
        .INST_RIADDR (INST_RIADDR),
        .INST_ROADDR (INST_ROADDR),
        .INST_RVALID (INST_RVALID),
        .INST_RDATA  (INST_RDATA),
        .MEM_WAIT    (MEM_WAIT),
        .FLUSH       (FLUSH),
        .INVALIDATE  (INVALIDATE),
        .BUS_RREQ    (BUS_RREQ),
        .BUS_RADDR   (BUS_RADDR),
        .BUS_RACK    (BUS_RACK),
        .BUS_RVALID  (BUS_RVALID),
        .BUS_RDATA   (BUS_RDATA)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model: which word address each line holds, plus progress of a miss
    // (0 none, 1 waiting for accept, 2 waiting for data, 3 delivering).
    bit          lk;
    logic [31:0] lk_a;
    int          phase;
    logic [31:0] m_addr;
    bit          m_drop, m_inv;
    bit          line_ok [N];
    logic [31:0] line_a  [N];
    logic [31:0] h_data, h_addr;

    // Responder.
    bit          armed, outst, force_rv, spur;
    int          ack_wait, dwait, ack_cfg, data_cfg;
    logic [31:0] r_addr;

    bit          obs_wait, obs_rv, obs_rreq;
    logic [31:0] obs_data, obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit cacheable(input logic [31:0] a);
        logic [63:0] x, lo, hi;
        x  = {32'b0, a};
        lo = {32'b0, BASE};
        hi = lo + {32'b0, SIZE};
        return (x >= lo) && (x < hi);
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a - BASE) * 32'h9E37_79B1 + 32'h13;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic bit hit_now();
        int i;
        i = idx_of(lk_a);
        return phase == 0 && lk && cacheable(lk_a) && line_ok[i] && line_a[i] == lk_a;
    endfunction

    function automatic bit miss_now();
        return phase == 0 && lk && !hit_now();
    endfunction

    task automatic model_reset();
        lk = 0; lk_a = 0; phase = 0; m_addr = 0; m_drop = 0; m_inv = 0;
        h_data = 0; h_addr = 0;
        for (int i = 0; i < N; i++) begin
            line_ok[i] = 0;
            line_a[i]  = 0;
        end
    endtask

    task automatic resp_reset();
        armed = 0; outst = 0; ack_wait = 0; dwait = 0; r_addr = 0;
    endtask

    task automatic step(input bit rden, input logic [31:0] a, input bit fl, input bit inv);
        bit          rack, rv, newack, h, md, erv;
        logic [31:0] rd, ed, ea;
        int          i;
        @(negedge CLK);
        rack = 0; rv = 0; newack = 0; rd = $urandom;
        if (BUS_RREQ === 1'b1) begin
            if (!armed) begin
                armed    = 1;
                ack_wait = (ack_cfg < 0) ? int'($urandom_range(0, 3)) : ack_cfg;
            end
            if (ack_wait == 0) begin
                rack = 1; newack = 1; armed = 0; r_addr = BUS_RADDR;
            end else begin
                ack_wait--;
            end
        end else if (spur && $urandom_range(0, 7) == 0) begin
            rack = 1;
        end
        if (outst) begin
            if (dwait == 0) begin
                rv = 1; rd = mem(r_addr); outst = 0;
            end else begin
                dwait--;
            end
        end else if (force_rv || (spur && $urandom_range(0, 7) == 0)) begin
            rv = 1; force_rv = 0;
        end
        if (newack) begin
            outst = 1;
            dwait = (data_cfg < 0) ? int'($urandom_range(0, 3)) : data_cfg;
        end
        INST_RDEN = rden; INST_RIADDR = a; FLUSH = fl; INVALIDATE = inv;
        BUS_RACK = rack; BUS_RVALID = rv; BUS_RDATA = rd;
        #1;
        h   = hit_now();
        md  = phase == 0 && lk && !h;
        erv = (h && !fl) || (phase == 3 && !m_drop);
        ed  = (phase == 3) ? mem(m_addr) : mem(lk_a);
        ea  = (phase == 3) ? m_addr : lk_a;
        if (erv) begin
            h_data = ed;
            h_addr = ea;
        end
        chkb("mem_wait", MEM_WAIT, md || phase == 1 || phase == 2);
        chkb("rvalid", INST_RVALID, erv);
        chk("rdata", INST_RDATA, h_data);
        chk("roaddr", INST_ROADDR, h_addr);
        chkb("bus_rreq", BUS_RREQ, phase == 1);
        if (phase == 1) chk("bus_raddr", BUS_RADDR, m_addr);
        obs_wait = MEM_WAIT; obs_rv = INST_RVALID; obs_rreq = BUS_RREQ;
        obs_data = INST_RDATA; obs_addr = INST_ROADDR;
        @(posedge CLK);
        case (phase)
            0: begin
                if (md) begin
                    phase = 1; m_addr = lk_a; m_drop = fl; m_inv = inv; lk = 0;
                end else begin
                    lk = rden;
                    if (rden) lk_a = {a[31:2], 2'b00};
                end
            end
            1: begin
                m_drop |= fl; m_inv |= inv;
                if (rack) phase = 2;
            end
            2: begin
                m_drop |= fl; m_inv |= inv;
                if (rv) phase = 3;
            end
            default: begin
                i = idx_of(m_addr);
                line_a[i]  = m_addr;
                line_ok[i] = cacheable(m_addr) && !m_inv;
                phase = 0; lk = 0;
            end
        endcase
        if (inv) begin
            for (int k = 0; k < N; k++) line_ok[k] = 0;
        end
    endtask

    task automatic run_read(input logic [31:0] a, output int lat, output int nreq,
                            output int waits, output logic [31:0] d, output logic [31:0] ra);
        bit prev;
        prev = 0; lat = -1; nreq = 0; waits = 0; d = 0; ra = 0;
        step(1, a, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            step(0, 32'h0, 0, 0);
            waits += int'(obs_wait);
            if (obs_rreq && !prev) nreq++;
            prev = obs_rreq;
            if (obs_rv) begin
                lat = k; d = obs_data; ra = obs_addr;
                break;
            end
        end
        chkb("read_done", lat > 0, 1'b1);
    endtask

    initial begin
        int          lat, nreq, waits, cnt;
        logic [31:0] d, ra;
        bit          inv, seen;
        RST = 1; INST_RDEN = 0; INST_RIADDR = 0; FLUSH = 0; INVALIDATE = 0;
        BUS_RACK = 0; BUS_RVALID = 0; BUS_RDATA = 0;
        spur = 0; force_rv = 0; ack_cfg = 1; data_cfg = 0;
        model_reset(); resp_reset();
        repeat (2) @(negedge CLK);
        #1;
        chkb("rst_rvalid", INST_RVALID, 1'b0);
        chkb("rst_wait", MEM_WAIT, 1'b0);
        chkb("rst_rreq", BUS_RREQ, 1'b0);
        chk("rst_rdata", INST_RDATA, 32'h0);
        chk("rst_roaddr", INST_ROADDR, 32'h0);
        chk("rst_raddr", BUS_RADDR, 32'h0);
        @(negedge CLK);
        RST = 0;

        run_read(32'h2000_0000, lat, nreq, waits, d, ra);
        chk("t1_wait_cycles", waits, 4);
        chk("t1_latency", lat, 5);
        chk("t1_rdata", d, 32'h0000_0013);
        chk("t1_roaddr", ra, 32'h2000_0000);
        chk("t1_bus_reads", nreq, 1);

        ack_cfg = 0;
        run_read(32'h2000_0000, lat, nreq, waits, d, ra);
        chk("t2_latency", lat, 1);
        chk("t2_bus_reads", nreq, 0);
        chk("t2_waits", waits, 0);
        run_read(32'h2000_0004, lat, nreq, waits, d, ra);
        run_read(32'h2000_0008, lat, nreq, waits, d, ra);
        step(1, 32'h2000_0000, 0, 0);
        step(1, 32'h2000_0004, 0, 0);
        chkb("t2_b2b_v0", obs_rv, 1'b1);
        chk("t2_b2b_a0", obs_addr, 32'h2000_0000);
        step(1, 32'h2000_0008, 0, 0);
        chkb("t2_b2b_v1", obs_rv, 1'b1);
        chk("t2_b2b_a1", obs_addr, 32'h2000_0004);
        step(0, 32'h0, 0, 0);
        chkb("t2_b2b_v2", obs_rv, 1'b1);
        chk("t2_b2b_a2", obs_addr, 32'h2000_0008);

        run_read(32'h2000_0040, lat, nreq, waits, d, ra);
        chk("t3_conflict_fill", nreq, 1);
        run_read(32'h2000_0000, lat, nreq, waits, d, ra);
        chk("t3_evicted_miss", nreq, 1);
        chk("t3_rdata", d, mem(32'h2000_0000));

        data_cfg = 2;
        step(1, 32'h2000_0110, 0, 0);
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 1, 0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 32'h0, 0, 0);
            cnt += int'(obs_rv);
        end
        chk("t4_flushed_pulses", cnt, 0);
        run_read(32'h2000_0110, lat, nreq, waits, d, ra);
        chk("t4_hit_after_flush", nreq, 0);
        chk("t4_latency", lat, 1);
        data_cfg = 0;

        run_read(32'h2000_0004, lat, nreq, waits, d, ra);
        chk("t5_pre_inv_hit", nreq, 0);
        step(0, 32'h0, 0, 1);
        run_read(32'h2000_0004, lat, nreq, waits, d, ra);
        chk("t5_inv_miss_a", nreq, 1);
        run_read(32'h2000_0000, lat, nreq, waits, d, ra);
        chk("t5_inv_miss_b", nreq, 1);
        step(1, 32'h2000_0008, 0, 0);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            inv = (phase == 3);
            step(0, 32'h0, 0, inv);
            if (inv) begin
                seen = 1;
                chkb("t5_done_rvalid", obs_rv, 1'b1);
            end
        end
        chkb("t5_done_seen", seen, 1'b1);
        run_read(32'h2000_0008, lat, nreq, waits, d, ra);
        chk("t5_done_line_invalid", nreq, 1);

        run_read(32'h1000_0000, lat, nreq, waits, d, ra);
        chk("t6_nc_first", nreq, 1);
        run_read(32'h1000_0000, lat, nreq, waits, d, ra);
        chk("t6_nc_second", nreq, 1);
        run_read(32'h2FFF_FFFC, lat, nreq, waits, d, ra);
        run_read(32'h2FFF_FFFC, lat, nreq, waits, d, ra);
        chk("t6_top_word_hit", nreq, 0);
        run_read(32'h3000_0000, lat, nreq, waits, d, ra);
        run_read(32'h3000_0000, lat, nreq, waits, d, ra);
        chk("t6_past_window", nreq, 1);

        ack_cfg = 3;
        run_read(32'h2000_0004, lat, nreq, waits, d, ra);
        step(1, 32'h2000_0200, 0, 0);
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 0);
        chkb("t6_in_req", obs_rreq, 1'b1);
        @(negedge CLK);
        INST_RDEN = 0; FLUSH = 0; INVALIDATE = 0; BUS_RACK = 0; BUS_RVALID = 0;
        #2 RST = 1;
        #1;
        chkb("t6_rst_rreq", BUS_RREQ, 1'b0);
        chkb("t6_rst_wait", MEM_WAIT, 1'b0);
        chkb("t6_rst_rvalid", INST_RVALID, 1'b0);
        @(negedge CLK);
        RST = 0;
        model_reset(); resp_reset();
        force_rv = 1;
        ack_cfg = 0;
        run_read(32'h2000_0004, lat, nreq, waits, d, ra);
        chk("t6_rst_cleared", nreq, 1);
        chk("t6_rst_rdata", d, mem(32'h2000_0004));

        ack_cfg = -1; data_cfg = -1; spur = 1;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            int          sel;
            bit          fl, rden;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)
                a = BASE + 32'($urandom_range(0, 2)) * 32'h40 + 32'($urandom_range(0, 15)) * 4;
            else if (sel == 7)
                a = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4;
            else if (sel == 8)
                a = 32'h2FFF_FFC0 + 32'($urandom_range(0, 15)) * 4;
            else
                a = 32'h3000_0000 + 32'($urandom_range(0, 15)) * 4;
            a    = a | 32'($urandom_range(0, 3));
            rden = $urandom_range(0, 3) != 0;
            fl   = (phase == 1 || phase == 2 || (phase == 0 && !miss_now()))
                   && $urandom_range(0, 19) == 0;
            inv  = $urandom_range(0, 49) == 0;
            step(rden, a, fl, inv);
        end
        spur = 0;
        repeat (20) step(0, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
